mlp_operand_streamer: RTL and testbench
=======================================

Name: mlp_operand_streamer

Overview:
Producer side of the neuron MAC datapath. Buffers signed 4-bit input/weight nibble pairs written over a byte interface and, on start, clears the MAC accumulator. It then streams one pair per cycle into the MAC and captures the final 16-bit ReLU result with a done pulse. Sits between the TinyTapeout pin interface and the MAC/accumulator, replacing direct pin-driven i/w feeding.

Parameters:
DEPTH, 8, number of (i,w) pairs the buffer holds; power of two, 2..16
CW, 5, width of count/index registers; must hold DEPTH (clog2(DEPTH)+1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
wr_valid  input  1  write request for one pair
wr_data  input  8  {w[3:0], i[3:0]}, both two's complement
wr_ready  output  1  pair accepted when wr_valid && wr_ready at posedge
start  input  1  single-cycle run request
mac_clr  output  1  clear accumulator total to 0 this cycle
mac_i  output  4  input nibble to MAC
mac_w  output  4  weight nibble to MAC
mac_valid  output  1  accumulator updates total <= total + mac_i*mac_w this cycle
mac_relu  input  16  combinational ReLU of (total + mac_i*mac_w) from MAC
result  output  16  captured ReLU result
result_valid  output  1  result holds a completed run
done  output  1  one-cycle pulse on completion
count  output  CW  pairs currently buffered
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, count=0, result=0, result_valid=0, done=0, mac_clr=0, mac_valid=0, mac_i=mac_w=0. Buffer contents are don't-care. Reset mid-run aborts immediately; no done.
- FSM states: IDLE, CLEAR, RUN, CAPTURE.
- IDLE: wr_ready = (count < DEPTH). An accepted write stores to buf[count]; count increments. When full, wr_ready=0 and wr_valid is ignored; no overwrite.
- IDLE, start=1, count>0 (post-write count): go to CLEAR, and result_valid <= 0. A write accepted on the same edge is included in the run. start with count==0 is ignored.
- CLEAR (1 cycle): mac_clr=1, mac_valid=0, mac_i=mac_w=0. Latch run length N=count and reset idx=0. Next state is RUN.
- RUN (N cycles): mac_i/mac_w = buf[idx], mac_valid=1, mac_clr=0. idx increments each cycle. After idx==N-1, go to CAPTURE.
- CAPTURE (1 cycle): mac_i=mac_w=0, mac_valid=0, so mac_relu = relu(total). result <= mac_relu; result_valid <= 1; done <= 1 (registered); state <= IDLE. count <= 0 (see Optional Feature).
- done is high exactly one cycle, in the first IDLE cycle after CAPTURE.
- Latency: if start is sampled at edge E, done and result_valid are high after edge E+N+2.
- Outside RUN, mac_i, mac_w and mac_valid are always 0.
- In CLEAR/RUN/CAPTURE: wr_ready=0 and start is ignored.
- Arithmetic is done by the MAC, not here. Products are signed 4x4 -> 8b. The accumulator is 16b, wraps modulo 2^16, and its ReLU output is 0 for total <= 0.
- result is stable until the next accepted start.

Optional Feature:
MLP_STREAM_REPLAY_EN
- Defined: count is retained at CAPTURE, so the buffered vector is kept. A new start re-runs the same N pairs. A write in IDLE appends if not full.
- Adds input clear_buf (1b). In IDLE only, clear_buf=1 sets count=0; clear_buf has priority over a same-cycle write and over start.
- Undefined: count <= 0 at CAPTURE, and the clear_buf port does not exist.

Test Plan:
- Write (i=3,w=2) then (i=0xF,w=4), then pulse start -> mac_clr high 1 cycle; mac_valid high 2 cycles with pairs in order; result=0x0002 after edge start+4; done pulses once; count=0.
- Write (i=0x8,w=7) (-8*7=-56), start -> result=0x0000 (ReLU); result_valid=1.
- DEPTH=8, write 8x (i=0x8,w=0x8) (+64 each), start -> result=0x0200; a 9th write before start is held off with wr_ready=0 and count stays 8.
- start with count=0 -> busy stays 0, no mac_clr, no done. wr_valid and start on the same edge with count=0 -> run of N=1.
- Assert rst_n=0 during RUN at idx=2 of 5 -> all outputs 0 asynchronously, count=0. After release, no done; the next run behaves normally.
- MLP_STREAM_REPLAY_EN: run (3,2),(1,1) -> result=7; start again -> result=7, count=2; clear_buf -> count=0.

Source files
------------

// File: rtl/mlp_operand_streamer.sv
// Operand streamer for the neuron MAC: buffers signed nibble pairs, clears the
// accumulator, streams one pair per cycle, then captures the ReLU result.
// Optional replay/clear_buf support is enabled by defining MLP_STREAM_REPLAY_EN.
module mlp_operand_streamer #(
    parameter int DEPTH = 8,
    parameter int CW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_valid,
    input  logic [7:0]    wr_data,
    output logic          wr_ready,
    input  logic          start,
`ifdef MLP_STREAM_REPLAY_EN
    input  logic          clear_buf,
`endif
    output logic          mac_clr,
    output logic [3:0]    mac_i,
    output logic [3:0]    mac_w,
    output logic          mac_valid,
    input  logic [15:0]   mac_relu,
    output logic [15:0]   result,
    output logic          result_valid,
    output logic          done,
    output logic [CW-1:0] count,
    output logic          busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_CAP   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] n_q, n_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [15:0]   result_q, result_d;
    logic          result_valid_q, result_valid_d;
    logic          done_q, done_d;
    logic [7:0]    buf_q [DEPTH];
    logic [7:0]    rd_pair;
    logic          in_idle, in_run, clr_req, wr_fire;

    assign in_idle = (state_q == S_IDLE);
    assign in_run  = (state_q == S_RUN);

`ifdef MLP_STREAM_REPLAY_EN
    assign clr_req = in_idle && clear_buf;
`else
    assign clr_req = 1'b0;
`endif

    assign wr_ready = in_idle && (count_q < DEPTH_C);
    // A clear in the same cycle wins over the write, so the pair is dropped.
    assign wr_fire  = wr_valid && wr_ready && !clr_req;

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        n_d            = n_q;
        idx_d          = idx_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        done_d         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clr_req) begin
                    count_d = '0;
                end else begin
                    if (wr_fire) count_d = count_q + CW'(1);
                    // Post-write count decides, so a same-edge write joins the run.
                    if (start && (count_d != '0)) begin
                        state_d        = S_CLEAR;
                        result_valid_d = 1'b0;
                    end
                end
            end
            S_CLEAR: begin
                n_d     = count_q;
                idx_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                idx_d = idx_q + CW'(1);
                if (idx_q == n_q - CW'(1)) state_d = S_CAP;
            end
            default: begin
                result_d       = mac_relu;
                result_valid_d = 1'b1;
                done_d         = 1'b1;
                state_d        = S_IDLE;
`ifndef MLP_STREAM_REPLAY_EN
                count_d        = '0;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            count_q        <= '0;
            n_q            <= '0;
            idx_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            n_q            <= n_d;
            idx_q          <= idx_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            done_q         <= done_d;
        end
    end

    // Buffer contents are don't-care after reset; only count qualifies them.
    always_ff @(posedge clk) begin
        if (wr_fire) buf_q[count_q[AW-1:0]] <= wr_data;
    end

    assign rd_pair      = buf_q[idx_q[AW-1:0]];
    assign mac_clr      = (state_q == S_CLEAR);
    assign mac_valid    = in_run;
    assign mac_i        = in_run ? rd_pair[3:0] : 4'd0;
    assign mac_w        = in_run ? rd_pair[7:4] : 4'd0;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign done         = done_q;
    assign count        = count_q;
    assign busy         = !in_idle;

endmodule

// File: tb/tb_mlp_operand_streamer.sv
// Bench for mlp_operand_streamer: behavioural MAC plus a pair-list reference model.
module tb_mlp_operand_streamer;
    localparam int DEPTH = 8;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_valid;
    logic [7:0]    wr_data;
    logic          wr_ready;
    logic          start;
    logic          clear_buf;
    logic          mac_clr;
    logic [3:0]    mac_i, mac_w;
    logic          mac_valid;
    logic [15:0]   mac_relu;
    logic [15:0]   result;
    logic          result_valid;
    logic          done;
    logic [CW-1:0] count;
    logic          busy;

    int checks = 0;
    int errors = 0;

    mlp_operand_streamer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .start(start),
`ifdef MLP_STREAM_REPLAY_EN
        .clear_buf(clear_buf),
`endif
        .mac_clr(mac_clr), .mac_i(mac_i), .mac_w(mac_w), .mac_valid(mac_valid),
        .mac_relu(mac_relu), .result(result), .result_valid(result_valid),
        .done(done), .count(count), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural accumulator standing in for the real MAC.
    logic [15:0]       total_q;
    logic signed [7:0] prod8;
    logic [15:0]       sum16;
    assign prod8    = $signed(mac_i) * $signed(mac_w);
    assign sum16    = total_q + {{8{prod8[7]}}, prod8};
    assign mac_relu = sum16[15] ? 16'd0 : sum16;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)         total_q <= '0;
        else if (mac_clr)   total_q <= '0;
        else if (mac_valid) total_q <= sum16;
    end

    logic [7:0] model_buf[$];
    logic [7:0] got[$];

    function automatic int sx4(input logic [3:0] x);
        return (x >= 4'd8) ? int'(x) - 16 : int'(x);
    endfunction

    function automatic logic [15:0] ref_result();
        int s = 0;
        logic [15:0] t;
        foreach (model_buf[j]) s += sx4(model_buf[j][3:0]) * sx4(model_buf[j][7:4]);
        t = s[15:0];
        return t[15] ? 16'd0 : t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_pair(input logic [3:0] i, input logic [3:0] w);
        bit rdy_exp;
        @(negedge clk);
        rdy_exp  = (model_buf.size() < DEPTH);
        wr_valid = 1'b1;
        wr_data  = {w, i};
        chk("wr_ready", wr_ready, rdy_exp);
        @(posedge clk);
        #1 wr_valid = 1'b0;
        if (rdy_exp) model_buf.push_back({w, i});
        chk("count_after_write", count, model_buf.size());
    endtask

    task automatic clear_model();
`ifdef MLP_STREAM_REPLAY_EN
        @(negedge clk);
        clear_buf = 1'b1;
        @(posedge clk);
        #1 clear_buf = 1'b0;
        model_buf.delete();
        chk("count_after_clear", count, 0);
`endif
    endtask

    // Pulses start (optionally with a same-edge write) and checks the whole run.
    task automatic run_check(input bit with_wr, input logic [7:0] d);
        int k, n, clr_cnt, bad_pairs, leak;
        bit finished;
        logic [15:0] exp_res;
        int exp_cnt;
        @(negedge clk);
        start = 1'b1;
        if (with_wr) begin wr_valid = 1'b1; wr_data = d; end
        @(posedge clk);
        #1 start = 1'b0; wr_valid = 1'b0;
        if (with_wr && model_buf.size() < DEPTH) model_buf.push_back(d);
        n = model_buf.size();
        exp_res = ref_result();
        k = 0; clr_cnt = 0; leak = 0; finished = 0;
        got.delete();
        while (k < 64 && !finished) begin
            @(negedge clk);
            if (k == 0) begin
                chk("busy_at_clear", busy, 1);
                chk("result_valid_dropped", result_valid, 0);
            end
            if (mac_clr) clr_cnt++;
            if (mac_valid) got.push_back({mac_w, mac_i});
            else if (mac_i != 0 || mac_w != 0) leak++;
            if (done) finished = 1;
            else k++;
        end
        chk("done_seen", finished, 1);
        chk("done_latency", k, n + 2);
        chk("mac_clr_cycles", clr_cnt, 1);
        chk("mac_valid_cycles", got.size(), n);
        bad_pairs = 0;
        foreach (got[j]) if (j < n && got[j] !== model_buf[j]) bad_pairs++;
        chk("pair_order", bad_pairs, 0);
        chk("idle_operands_zero", leak, 0);
        chk("result", result, exp_res);
        chk("result_valid", result_valid, 1);
        chk("busy_after", busy, 0);
`ifdef MLP_STREAM_REPLAY_EN
        exp_cnt = n;
`else
        exp_cnt = 0;
        model_buf.delete();
`endif
        chk("count_after_run", count, exp_cnt);
        @(negedge clk);
        chk("done_one_pulse", done, 0);
        chk("result_stable", result, exp_res);
    endtask

    initial begin
        int n, seen_done, seen_clr, seen_busy;
        rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; start = 1'b0; clear_buf = 1'b0;
        #2;
        chk("reset_outputs",
            {busy, count, result, result_valid, done, mac_clr, mac_valid, mac_i, mac_w}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Two-pair run: 3*2 + (-1)*4 = 2.
        clear_model();
        write_pair(4'h3, 4'h2);
        write_pair(4'hF, 4'h4);
        run_check(0, 8'h00);
        chk("tp1_result_const", result, 16'h0002);

        // Negative total clamps to zero.
        clear_model();
        write_pair(4'h8, 4'h7);
        run_check(0, 8'h00);
        chk("tp2_relu_zero", result, 16'h0000);

        // Full buffer, ninth write refused.
        clear_model();
        for (int j = 0; j < DEPTH; j++) write_pair(4'h8, 4'h8);
        write_pair(4'h1, 4'h1);
        chk("full_count_held", count, DEPTH);
        run_check(0, 8'h00);
        chk("tp3_full_result", result, 16'h0200);

        // start with empty buffer is ignored.
        clear_model();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        seen_done = 0; seen_clr = 0; seen_busy = 0;
        repeat (4) begin
            @(negedge clk);
            seen_done += done; seen_clr += mac_clr; seen_busy += busy;
        end
        chk("empty_start_ignored", {seen_done[7:0], seen_clr[7:0], seen_busy[7:0]}, 0);

        // Write and start on the same edge from empty: N=1.
        run_check(1, {4'h5, 4'h3});
        chk("same_edge_result", result, 16'd15);

        // Reset in the middle of a 5-pair run, at idx 2.
        clear_model();
        for (int j = 0; j < 5; j++) write_pair(4'($urandom), 4'($urandom));
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrun_valid", mac_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrun_reset_outputs",
            {busy, count, result, result_valid, done, mac_clr, mac_valid, mac_i, mac_w}, 0);
        model_buf.delete();
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        repeat (8) begin
            @(negedge clk);
            seen_done += done;
        end
        chk("no_done_after_abort", seen_done, 0);
        write_pair(4'h2, 4'h3);
        run_check(0, 8'h00);
        chk("post_reset_result", result, 16'd6);

        // Randomized runs against the reference model.
        for (int r = 0; r < 14; r++) begin
            clear_model();
            n = $urandom_range(1, DEPTH);
            for (int j = 0; j < n; j++) write_pair(4'($urandom), 4'($urandom));
            if (n < DEPTH && $urandom_range(0, 1) == 1) run_check(1, 8'($urandom));
            else run_check(0, 8'h00);
        end

`ifdef MLP_STREAM_REPLAY_EN
        clear_model();
        write_pair(4'h3, 4'h2);
        write_pair(4'h1, 4'h1);
        run_check(0, 8'h00);
        chk("replay_first", result, 16'd7);
        run_check(0, 8'h00);
        chk("replay_second", result, 16'd7);
        chk("replay_count", count, 2);
        clear_model();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
